sys_bus_ctrl: RTL and testbench

Parametrised 65C02 system-bus controller that replaces the hand-wired clock-enable, address-decode and data-mux logic in the top level. It registers the core's early AB/DO/WE outputs on a divided clock enable and decodes RAM, ROM, N I/O slots and external space. It inserts programmable wait states for external-bus cycles by withholding RDY. It also muxes read data, with per-slot registered or combinational I/O read paths.

---
 rtl/sys_bus_pkg.sv | 26 ++
 rtl/bus_clken_gen.sv | 30 +++
 rtl/sys_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sys_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - shared types and address-window helper for the 65C02 bus controller
package sys_bus_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_ROM,
    REG_IO,
    REG_EXT
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  localparam int unsigned IO_WIN_BYTES = 16;

  // True when addr falls in the 16-byte window of slot k
  function automatic logic io_hit(input logic [15:0] addr, input int unsigned k,
                                  input logic [15:0] base, input logic [15:0] stride);
    logic [31:0] win;
    win = {16'd0, base} + k * {16'd0, stride};
    return ({16'd0, addr} >= win) && ({16'd0, addr} < win + IO_WIN_BYTES);
  endfunction

endpackage

// File: rtl/bus_clken_gen.sv
// rtl/bus_clken_gen.sv - free-running CPU clock enable, phi2 and delayed I/O enable
module bus_clken_gen #(
  parameter int CLKEN_BITS = 2
) (
  input  logic clk,
  input  logic resb,
  input  logic cpu_rdy,
  output logic tick,
  output logic phi2,
  output logic io_clken
);

  logic [CLKEN_BITS-1:0] ctr;

  // Counter never stalls so phi2 keeps running through wait states
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      ctr      <= '0;
      tick     <= 1'b0;
      io_clken <= 1'b0;
    end else begin
      ctr      <= ctr + CLKEN_BITS'(1);
      tick     <= &ctr;
      io_clken <= cpu_rdy;
    end
  end

  assign phi2 = ctr[CLKEN_BITS-1];

endmodule

// File: rtl/sys_bus_ctrl.sv
// rtl/sys_bus_ctrl.sv - 65C02 system-bus controller: clock enable, decode, wait states, read mux
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int          CLKEN_BITS    = 2,
  parameter int          RAM_ADDR_BITS = 15,
  parameter int          ROM_ADDR_BITS = 14,
  parameter int          IO_SLOTS      = 2,
  parameter logic [15:0] IO_BASE       = 16'h8000,
  parameter logic [15:0] IO_STRIDE     = 16'h0800,
  parameter logic [7:0]  IO_REG_MASK   = 8'b0000_0010,
  parameter int          EXT_WAIT      = 2
) (
  input  logic                  clk,
  input  logic                  resb,
  input  logic [15:0]           cpu_addr_next,
  input  logic [7:0]            cpu_dout_next,
  input  logic                  cpu_we_next,
  output logic                  cpu_rdy,
  output logic [7:0]            cpu_din,
  output logic [15:0]           bus_addr,
  output logic [7:0]            bus_dout,
  output logic                  bus_we,
  input  logic [7:0]            ram_dout,
  input  logic [7:0]            rom_dout,
  output logic                  ram_we,
  input  logic [8*IO_SLOTS-1:0] io_dout,
  output logic [IO_SLOTS-1:0]   io_sel,
  output logic [IO_SLOTS-1:0]   io_strobe,
  output logic                  io_clken,
  input  logic [7:0]            ext_din,
  output logic [7:0]            ext_dout,
  output logic                  ext_oe,
  output logic                  phi2
);

  localparam logic [16:0] RAM_TOP   = 17'(1) << RAM_ADDR_BITS;
  localparam logic [16:0] ROM_BASE  = 17'(65536) - (17'(1) << ROM_ADDR_BITS);
  localparam logic [3:0]  WAIT_INIT = 4'(EXT_WAIT);
  localparam logic        HAS_WAIT  = (EXT_WAIT != 0);

  // RAM beats ROM beats any I/O slot; everything else is external space
  function automatic region_e region_of(input logic [15:0] a);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < IO_SLOTS; k++) begin
      hit = hit | io_hit(a, k, IO_BASE, IO_STRIDE);
    end
    if ({1'b0, a} < RAM_TOP)        return REG_RAM;
    else if ({1'b0, a} >= ROM_BASE) return REG_ROM;
    else if (hit)                   return REG_IO;
    else                            return REG_EXT;
  endfunction

  logic                tick;
  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  region_e             bus_region;
  logic                next_is_ext;
  logic [IO_SLOTS-1:0] slot_sel;
  logic [7:0]          rd_r  [IO_SLOTS];
  logic [7:0]          io_rd [IO_SLOTS];

  bus_clken_gen #(
    .CLKEN_BITS(CLKEN_BITS)
  ) u_clken (
    .clk     (clk),
    .resb    (resb),
    .cpu_rdy (cpu_rdy),
    .tick    (tick),
    .phi2    (phi2),
    .io_clken(io_clken)
  );

  assign cpu_rdy     = tick & (state_q == ST_IDLE);
  assign next_is_ext = (region_of(cpu_addr_next) == REG_EXT);

  // Capture the core's early outputs at the end of each bus cycle
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      bus_addr <= '0;
      bus_dout <= '0;
      bus_we   <= 1'b0;
    end else if (cpu_rdy) begin
      bus_addr <= cpu_addr_next;
      bus_dout <= cpu_dout_next;
      bus_we   <= cpu_we_next;
    end
  end

  // Wait-state FSM registers
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // External cycles hold off RDY; the entry decision looks at the address about to be latched
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_rdy && next_is_ext && HAS_WAIT) begin
          state_d = ST_WAIT;
          wcnt_d  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode the held address; lowest matching slot wins an overlap
  always_comb begin
    bus_region = region_of(bus_addr);
    slot_sel   = '0;
    if (bus_region == REG_IO) begin
      for (int k = IO_SLOTS - 1; k >= 0; k--) begin
        if (io_hit(bus_addr, k, IO_BASE, IO_STRIDE)) begin
          slot_sel    = '0;
          slot_sel[k] = 1'b1;
        end
      end
    end
  end

  assign io_sel    = slot_sel;
  assign io_strobe = slot_sel & {IO_SLOTS{cpu_rdy}};
  assign ram_we    = (bus_region == REG_RAM) & bus_we & cpu_rdy;

  // Registered slots sample their peripheral on the P2-style enable
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      for (int k = 0; k < IO_SLOTS; k++) rd_r[k] <= '0;
    end else begin
      for (int k = 0; k < IO_SLOTS; k++) begin
        if (io_clken && IO_REG_MASK[k]) rd_r[k] <= io_dout[8*k +: 8];
      end
    end
  end

  // Per-slot choice between the captured and the live read path
  always_comb begin
    for (int k = 0; k < IO_SLOTS; k++) begin
      io_rd[k] = IO_REG_MASK[k] ? rd_r[k] : io_dout[8*k +: 8];
    end
  end

  // Read-data mux in decode priority order
  always_comb begin
    cpu_din = ext_din;
    case (bus_region)
      REG_RAM: cpu_din = ram_dout;
      REG_ROM: cpu_din = rom_dout;
      REG_IO: begin
        for (int k = 0; k < IO_SLOTS; k++) begin
          if (slot_sel[k]) cpu_din = io_rd[k];
        end
      end
      default: cpu_din = ext_din;
    endcase
  end

  // Drive writes outward and mirror internal reads; float only on external reads
  always_comb begin
    ext_oe   = bus_we | (bus_region != REG_EXT);
    ext_dout = bus_we ? bus_dout : cpu_din;
  end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb/tb_sys_bus_ctrl.sv - randomized model-checked bench for sys_bus_ctrl
module tb_sys_bus_ctrl;

  localparam int          CLKEN_BITS  = 2;
  localparam int          RAM_BITS    = 15;
  localparam int          ROM_BITS    = 14;
  localparam int          IO_SLOTS    = 2;
  localparam int          IO_BASE     = 'h8000;
  localparam int          IO_STRIDE   = 'h0800;
  localparam logic [7:0]  IO_REG_MASK = 8'b0000_0010;
  localparam int          EXT_WAIT    = 2;
  localparam int          PERIOD      = 1 << CLKEN_BITS;

  localparam int R_RAM = 0, R_ROM = 1, R_EXT = 2, R_IO0 = 3;
  localparam logic [15:0] EDGE_ADDRS [9] = '{16'h7FFF, 16'h8000, 16'h800F, 16'h8010, 16'h87FF,
                                            16'h880F, 16'h8810, 16'hBFFF, 16'hC000};

  logic                  clk = 1'b0;
  logic                  resb = 1'b0;
  logic [15:0]           cpu_addr_next;
  logic [7:0]            cpu_dout_next;
  logic                  cpu_we_next;
  logic                  cpu_rdy;
  logic [7:0]            cpu_din;
  logic [15:0]           bus_addr;
  logic [7:0]            bus_dout;
  logic                  bus_we;
  logic [7:0]            ram_dout;
  logic [7:0]            rom_dout;
  logic                  ram_we;
  logic [8*IO_SLOTS-1:0] io_dout;
  logic [IO_SLOTS-1:0]   io_sel;
  logic [IO_SLOTS-1:0]   io_strobe;
  logic                  io_clken;
  logic [7:0]            ext_din;
  logic [7:0]            ext_dout;
  logic                  ext_oe;
  logic                  phi2;

  int tests = 0;
  int fails = 0;
  logic rand_en = 1'b0;

  sys_bus_ctrl #(
    .CLKEN_BITS   (CLKEN_BITS),
    .RAM_ADDR_BITS(RAM_BITS),
    .ROM_ADDR_BITS(ROM_BITS),
    .IO_SLOTS     (IO_SLOTS),
    .IO_BASE      (16'(IO_BASE)),
    .IO_STRIDE    (16'(IO_STRIDE)),
    .IO_REG_MASK  (IO_REG_MASK),
    .EXT_WAIT     (EXT_WAIT)
  ) dut (
    .clk          (clk),
    .resb         (resb),
    .cpu_addr_next(cpu_addr_next),
    .cpu_dout_next(cpu_dout_next),
    .cpu_we_next  (cpu_we_next),
    .cpu_rdy      (cpu_rdy),
    .cpu_din      (cpu_din),
    .bus_addr     (bus_addr),
    .bus_dout     (bus_dout),
    .bus_we       (bus_we),
    .ram_dout     (ram_dout),
    .rom_dout     (rom_dout),
    .ram_we       (ram_we),
    .io_dout      (io_dout),
    .io_sel       (io_sel),
    .io_strobe    (io_strobe),
    .io_clken     (io_clken),
    .ext_din      (ext_din),
    .ext_dout     (ext_dout),
    .ext_oe       (ext_oe),
    .phi2         (phi2)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory map as address ranges
  function automatic int region_of(input logic [15:0] a);
    int ai;
    int base;
    ai = int'(a);
    if (ai < (1 << RAM_BITS)) return R_RAM;
    if (ai >= 65536 - (1 << ROM_BITS)) return R_ROM;
    for (int s = 0; s < IO_SLOTS; s++) begin
      base = IO_BASE + s * IO_STRIDE;
      if (ai >= base && ai < base + 16) return R_IO0 + s;
    end
    return R_EXT;
  endfunction

  // Model: clocks since reset release, when the next RDY is due, what the bus holds
  int          k = 0;
  int          next_rdy = PERIOD;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_dout = '0;
  logic        m_we = 1'b0;
  logic        m_clken = 1'b0;
  logic [7:0]  rd_m [IO_SLOTS];

  always @(posedge clk or negedge resb) begin
    if (!resb) begin
      k        <= 0;
      next_rdy <= PERIOD;
      m_addr   <= '0;
      m_dout   <= '0;
      m_we     <= 1'b0;
      m_clken  <= 1'b0;
      for (int s = 0; s < IO_SLOTS; s++) rd_m[s] <= '0;
    end else begin
      for (int s = 0; s < IO_SLOTS; s++) begin
        if (m_clken && IO_REG_MASK[s]) rd_m[s] <= io_dout[8*s +: 8];
      end
      m_clken <= (k == next_rdy);
      if (k == next_rdy) begin
        m_addr   <= cpu_addr_next;
        m_dout   <= cpu_dout_next;
        m_we     <= cpu_we_next;
        next_rdy <= k + PERIOD * (1 + ((region_of(cpu_addr_next) == R_EXT) ? EXT_WAIT : 0));
      end
      k <= k + 1;
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    int   r, s, e_din, e_sel;
    logic e_rdy, e_oe;
    #2;
    if (!resb) begin
      chk("rst_cpu_rdy", cpu_rdy, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_io_sel", io_sel, 0);
      chk("rst_io_strobe", io_strobe, 0);
      chk("rst_io_clken", io_clken, 0);
      chk("rst_phi2", phi2, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_dout", bus_dout, 0);
    end else begin
      r     = region_of(m_addr);
      s     = (r >= R_IO0) ? r - R_IO0 : 0;
      e_rdy = (k == next_rdy);
      if (r == R_RAM)      e_din = int'(ram_dout);
      else if (r == R_ROM) e_din = int'(rom_dout);
      else if (r == R_EXT) e_din = int'(ext_din);
      else e_din = IO_REG_MASK[s] ? int'(rd_m[s]) : int'(io_dout[8*s +: 8]);
      e_sel = (r >= R_IO0) ? (1 << s) : 0;
      e_oe  = m_we || (r != R_EXT);
      chk("cpu_rdy", cpu_rdy, e_rdy);
      chk("phi2", phi2, (k >> (CLKEN_BITS - 1)) & 1);
      chk("io_clken", io_clken, m_clken);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_dout", bus_dout, m_dout);
      chk("bus_we", bus_we, m_we);
      chk("cpu_din", cpu_din, e_din);
      chk("io_sel", io_sel, e_sel);
      chk("io_strobe", io_strobe, e_rdy ? e_sel : 0);
      chk("ram_we", ram_we, (e_rdy && m_we && r == R_RAM) ? 1 : 0);
      chk("ext_oe", ext_oe, e_oe);
      if (e_oe) chk("ext_dout", ext_dout, m_we ? int'(m_dout) : e_din);
    end
  end

  task automatic tick_neg();
    @(negedge clk);
    if (rand_en) begin
      ram_dout = 8'($urandom);
      rom_dout = 8'($urandom);
      io_dout  = (8*IO_SLOTS)'($urandom);
      ext_din  = 8'($urandom);
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      tick_neg();
      #3;
      n++;
    end while (!cpu_rdy && n < 64);
    if (!cpu_rdy) begin
      tests++;
      fails++;
      $display("FAIL rdy_timeout: no cpu_rdy within %0d clk, required one", n);
    end
  endtask

  task automatic set_bus(input logic [15:0] a, input logic we, input logic [7:0] d);
    cpu_addr_next = a;
    cpu_we_next   = we;
    cpu_dout_next = d;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(0, 'h7FFF));
      1:       return 16'($urandom_range('hC000, 'hFFFF));
      2:       return 16'(IO_BASE + $urandom_range(0, IO_SLOTS - 1) * IO_STRIDE + $urandom_range(0, 15));
      3:       return 16'($urandom_range('h9000, 'hBFFF));
      4:       return EDGE_ADDRS[$urandom_range(0, 8)];
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    ram_dout = 8'h12;
    rom_dout = 8'h34;
    io_dout  = 16'hC311;
    ext_din  = 8'h77;
    set_bus(16'h0010, 1'b0, 8'h00);
    repeat (3) tick_neg();
    #3 resb = 1'b1;

    wait_rdy(n);
    chk("first_rdy_delay", n, 4);

    set_bus(16'h1234, 1'b1, 8'h5A);
    wait_rdy(n);
    chk("ram_wr_gap", n, 4);
    chk("ram_wr_addr", bus_addr, 'h1234);
    chk("ram_wr_we", ram_we, 1);
    chk("ram_wr_oe", ext_oe, 1);
    chk("ram_wr_ext_dout", ext_dout, 'h5A);
    chk("ram_wr_strobe", io_strobe, 0);

    set_bus(16'h8803, 1'b0, 8'h00);
    wait_rdy(n);
    chk("io1_reg_din", cpu_din, 'hC3);
    chk("io1_strobe", io_strobe, 'b10);

    io_dout = 16'hC33C;
    set_bus(16'h8001, 1'b0, 8'h00);
    wait_rdy(n);
    chk("io0_strobe", io_strobe, 'b01);
    chk("io0_din", cpu_din, 'h3C);
    io_dout = 16'hC396;
    #1 chk("io0_din_comb", cpu_din, 'h96);

    set_bus(16'h9000, 1'b0, 8'h00);
    wait_rdy(n);
    chk("ext_gap", n, 12);
    chk("ext_din", cpu_din, 'h77);
    chk("ext_oe_read", ext_oe, 0);
    chk("ext_addr_held", bus_addr, 'h9000);

    set_bus(16'hFFF0, 1'b1, 8'hAA);
    wait_rdy(n);
    chk("rom_wr_gap", n, 4);
    chk("rom_wr_ram_we", ram_we, 0);

    set_bus(16'hA123, 1'b0, 8'h00);
    wait_rdy(n);
    chk("ext2_gap", n, 12);

    set_bus(16'h9100, 1'b1, 8'h42);
    repeat (5) tick_neg();
    #3 resb = 1'b0;
    #1;
    chk("midwait_rst_bus_we", bus_we, 0);
    chk("midwait_rst_rdy", cpu_rdy, 0);
    chk("midwait_rst_addr", bus_addr, 0);
    set_bus(16'h0100, 1'b0, 8'h00);
    repeat (2) tick_neg();
    #3 resb = 1'b1;
    wait_rdy(n);
    chk("rst_first_rdy", n, 4);
    set_bus(16'h0200, 1'b0, 8'h00);
    wait_rdy(n);
    chk("rst_cadence", n, 4);

    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_bus(pick_addr(), 1'($urandom_range(0, 1)), 8'($urandom));
      wait_rdy(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
